// File: rtl/timer_sched.sv
// timer_sched: programmable interval timer. A prescaler gates a width-bit
// up-counter; expiry produces a one-cycle tick, then the timer either
// re-arms (periodic) or parks in DONE (one-shot). Config is shadowed at start.
module timer_sched #(
  parameter int width     = 8,
  parameter int pre_width = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 periodic,
  input  logic [width-1:0]     period,
  input  logic [pre_width-1:0] prescale,
  output logic [width-1:0]     cnt,
  output logic                 tick,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [width-1:0]     n_s_q, n_s_d;
  logic [pre_width-1:0] p_s_q, p_s_d;
  logic                 per_s_q, per_s_d;
  logic [pre_width-1:0] pre_q, pre_d;
  logic [width-1:0]     cnt_q, cnt_d;
  logic                 tick_q, tick_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // A start with period 0 is never accepted, so n_s_q-1 cannot underflow
  // while counting.
  logic             start_ok;
  logic [width-1:0] last_cnt;
  assign start_ok = start && (period != '0);
  assign last_cnt = n_s_q - width'(1);

  // Next-state, shadow capture, prescaler and counter sequencing.
  always_comb begin
    state_d = state_q;
    n_s_d   = n_s_q;
    p_s_d   = p_s_q;
    per_s_d = per_s_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        cnt_d = '0;
        pre_d = '0;
        if (stop) begin
          state_d = IDLE;
        end else if (start_ok) begin
          state_d = RUN;
          n_s_d   = period;
          p_s_d   = prescale;
          per_s_d = periodic;
        end
      end
      RUN: begin
        if (stop) begin
          // Abort wins over any coincident expiry.
          state_d = IDLE;
          cnt_d   = '0;
          pre_d   = '0;
        end else if (start_ok) begin
          // Restart with fresh config; coincident expiry is dropped.
          n_s_d   = period;
          p_s_d   = prescale;
          per_s_d = periodic;
          cnt_d   = '0;
          pre_d   = '0;
        end else if (pre_q == p_s_q) begin
          pre_d = '0;
          if (cnt_q == last_cnt) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            if (!per_s_q) state_d = DONE;
          end else begin
            cnt_d = cnt_q + width'(1);
          end
        end else begin
          pre_d = pre_q + pre_width'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pre_d   = '0;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_s_q   <= '0;
      p_s_q   <= '0;
      per_s_q <= 1'b0;
      pre_q   <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_s_q   <= n_s_d;
      p_s_q   <= p_s_d;
      per_s_q <= per_s_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign tick = tick_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched. Inputs change and outputs are sampled 1ns
// after each rising edge; "edge 0" is the edge that samples start.
module tb_timer_sched;

  logic       clk = 1'b0;
  logic       rst, start, stop, periodic;
  logic [7:0] period, cnt;
  logic [3:0] prescale;
  logic       tick, busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  timer_sched #(.width(8), .pre_width(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .periodic(periodic),
    .period(period), .prescale(prescale),
    .cnt(cnt), .tick(tick), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge with the given config (edge 0).
  task automatic do_start(input logic [7:0] n, input logic [3:0] p, input logic per);
    period = n; prescale = p; periodic = per; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    n_chk++;
    if ({cnt, tick, busy, done} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_state: cnt=%0d tick=%b busy=%b done=%b expected all 0", cnt, tick, busy, done);
    end
  endtask

  task automatic test_oneshot();
    int ec;
    do_start(8'd5, 4'd0, 1'b0);
    n_chk++;
    if (busy !== 1'b1 || cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL oneshot_start: busy=%b cnt=%0d expected busy=1 cnt=0", busy, cnt);
    end
    for (int k = 1; k <= 5; k++) begin
      step();
      ec = (k < 5) ? k : 0;
      n_chk++;
      if (cnt !== 8'(ec) || tick !== (k == 5) || busy !== (k < 5) || done !== (k == 5)) begin
        n_fail++;
        $display("FAIL oneshot_k%0d: cnt=%0d tick=%b busy=%b done=%b expected cnt=%0d tick=%b busy=%b done=%b",
                 k, cnt, tick, busy, done, ec, k == 5, k < 5, k == 5);
      end
    end
    for (int k = 0; k < 4; k++) begin
      step();
      n_chk++;
      if (tick !== 1'b0 || done !== 1'b1 || cnt !== 8'd0) begin
        n_fail++;
        $display("FAIL oneshot_hold: tick=%b done=%b cnt=%0d expected tick=0 done=1 cnt=0", tick, done, cnt);
      end
    end
    // Restart straight out of DONE.
    do_start(8'd2, 4'd0, 1'b0);
    n_chk++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_restart: busy=%b done=%b expected busy=1 done=0", busy, done);
    end
    step(); step();
    n_chk++;
    if (tick !== 1'b1 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_restart_tick: tick=%b done=%b expected 1 1", tick, done);
    end
    do_stop();
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_stop: done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_periodic_prescale();
    int ec;
    do_start(8'd3, 4'd2, 1'b1);
    for (int k = 1; k <= 30; k++) begin
      step();
      ec = (k / 3) % 3;
      n_chk++;
      if (cnt !== 8'(ec) || tick !== (k % 9 == 0) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL periodic_k%0d: cnt=%0d tick=%b busy=%b expected cnt=%0d tick=%b busy=1",
                 k, cnt, tick, busy, ec, k % 9 == 0);
      end
    end
    do_stop();
  endtask

  task automatic test_shadow();
    int nt;
    do_start(8'd4, 4'd0, 1'b1);
    period = 8'd7; prescale = 4'd5;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_chk++;
      if (tick !== (k % 4 == 0)) begin
        n_fail++;
        $display("FAIL shadow_old_k%0d: tick=%b expected %b", k, tick, k % 4 == 0);
      end
    end
    do_start(8'd7, 4'd5, 1'b1);
    nt = 0;
    for (int k = 1; k <= 84; k++) begin
      step();
      if (tick) nt++;
      if (k == 41 || k == 42 || k == 84) begin
        n_chk++;
        if (tick !== (k != 41)) begin
          n_fail++;
          $display("FAIL shadow_new_k%0d: tick=%b expected %b", k, tick, k != 41);
        end
      end
    end
    n_chk++;
    if (nt != 2) begin
      n_fail++;
      $display("FAIL shadow_new_count: ticks=%0d expected 2", nt);
    end
    do_stop();
  endtask

  task automatic test_collision();
    do_start(8'd2, 4'd0, 1'b0);
    step();
    stop = 1'b1;
    step();   // would have been the expiry edge
    stop = 1'b0;
    n_chk++;
    if (tick !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL stop_expiry: tick=%b busy=%b done=%b cnt=%0d expected 0 0 0 0", tick, busy, done, cnt);
    end
    step();
    n_chk++;
    if (tick !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_expiry_after: tick=%b done=%b expected 0 0", tick, done);
    end
    period = 8'd3; start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL start_stop_idle: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_period_zero();
    do_start(8'd0, 4'd0, 1'b1);
    n_chk++;
    if (busy !== 1'b0 || cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL zero_idle: busy=%b cnt=%0d expected 0 0", busy, cnt);
    end
    // Zero-period start while running is ignored; counting continues.
    do_start(8'd3, 4'd0, 1'b1);
    step();
    do_start(8'd0, 4'd0, 1'b1);
    n_chk++;
    if (busy !== 1'b1 || cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL zero_run: busy=%b cnt=%0d expected busy=1 cnt=2", busy, cnt);
    end
    step();
    n_chk++;
    if (tick !== 1'b1 || cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL zero_run_tick: tick=%b cnt=%0d expected 1 0", tick, cnt);
    end
    do_stop();
  endtask

  task automatic test_max_period();
    int first, mx;
    first = -1; mx = 0;
    do_start(8'd255, 4'd0, 1'b0);
    for (int k = 1; k <= 260; k++) begin
      step();
      if (int'(cnt) > mx) mx = int'(cnt);
      if (tick && first < 0) first = k;
    end
    n_chk++;
    if (first != 255) begin
      n_fail++;
      $display("FAIL max_tick_time: first tick at %0d expected 255", first);
    end
    n_chk++;
    if (mx != 254) begin
      n_fail++;
      $display("FAIL max_cnt: max cnt=%0d expected 254", mx);
    end
    n_chk++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL max_done: done=%b expected 1", done);
    end
    do_stop();
  endtask

  task automatic test_n1_continuous();
    do_start(8'd1, 4'd0, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      step();
      n_chk++;
      if (tick !== 1'b1 || cnt !== 8'd0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL n1_k%0d: tick=%b cnt=%0d busy=%b expected 1 0 1", k, tick, cnt, busy);
      end
    end
    do_stop();
    n_chk++;
    if (tick !== 1'b0) begin
      n_fail++;
      $display("FAIL n1_stop: tick=%b expected 0", tick);
    end
  endtask

  task automatic test_reset_mid();
    do_start(8'd8, 4'd0, 1'b1);
    step(); step(); step();
    n_chk++;
    if (cnt !== 8'd3) begin
      n_fail++;
      $display("FAIL rstmid_pre: cnt=%0d expected 3", cnt);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++;
    if ({cnt, tick, busy, done} !== 11'd0) begin
      n_fail++;
      $display("FAIL rstmid_state: cnt=%0d tick=%b busy=%b done=%b expected all 0", cnt, tick, busy, done);
    end
    do_start(8'd5, 4'd0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step();
      n_chk++;
      if (tick !== (k == 5) || cnt !== 8'((k < 5) ? k : 0)) begin
        n_fail++;
        $display("FAIL rstmid_restart_k%0d: tick=%b cnt=%0d expected tick=%b cnt=%0d",
                 k, tick, cnt, k == 5, (k < 5) ? k : 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; periodic = 1'b0;
    period = 8'd0; prescale = 4'd0;
    #1;
    test_reset();
    test_oneshot();
    test_periodic_prescale();
    test_shadow();
    test_collision();
    test_period_zero();
    test_max_period();
    test_n1_continuous();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_sched.md
# timer_sched

Programmable interval timer controller that owns and sequences a `width`-bit up-counter datapath through a prescaler. It generates single-cycle expiry ticks in one-shot or periodic mode. It sits between software-visible control strobes and any logic needing timed events, and replaces ad hoc enable/clear driving of bare counters. All control inputs are shadowed at start, so the running schedule is immune to input changes.

## Interface
- `width`, 8, bit width of counter and period
- `pre_width`, 4, bit width of prescale value
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  level-sampled strobe; (re)starts the timer with current config
- `stop`  in  1  level-sampled strobe; aborts to IDLE; priority over `start`
- `periodic`  in  1  mode select: 1 = periodic, 0 = one-shot; captured at start
- `period`  in  `width`  steps per expiry, N; captured at start; 0 is illegal
- `prescale`  in  `pre_width`  prescale value P; counter steps every P+1 cycles; captured at start
- `cnt`  out  `width`  current counter value, unsigned, registered
- `tick`  out  1  one-cycle registered pulse per expiry
- `busy`  out  1  high in RUN
- `done`  out  1  high in DONE; one-shot completed

## Operation
- **Internal registers:**
  - state ∈ {IDLE, RUN, DONE}
  - shadow regs: N_s, P_s, periodic_s
  - prescaler `pre` (`pre_width` bits)
  - `cnt`
- **Reset:** state=IDLE; `cnt`=0, `pre`=0, `tick`=0, `busy`=0, `done`=0, shadows=0.
- **IDLE:**
  - `cnt` and `pre` are held at 0.
  - `start`=1 with `period`≠0 and `stop`=0: capture shadows, `cnt`←0, `pre`←0, go to RUN.
  - `start` with `period`=0 is ignored; state stays IDLE.
- **RUN:**
  - The step condition is `pre`==P_s.
  - On step: `pre`←0 and the counter advances. Otherwise: `pre`←`pre`+1.
  - Advance with `cnt`<N_s−1: `cnt`←`cnt`+1.
  - Advance with `cnt`==N_s−1 (expiry): `cnt`←0 and `tick`←1 for the next cycle.
  - After expiry: if periodic_s, stay in RUN; else go to DONE.
- **DONE:**
  - `cnt`=0 and `done`=1.
  - `start` behaves as in IDLE (restart).
  - `stop`: go to IDLE.
  - Otherwise stay in DONE.
- **`stop` in RUN or DONE:**
  - Next cycle: IDLE, `cnt`=0, `pre`=0.
  - A coincident expiry is suppressed: no tick, no DONE.
- **`start` in RUN (without `stop`):**
  - Recapture shadows, `cnt`←0, `pre`←0, stay in RUN.
  - A coincident expiry is suppressed.
  - `start` with `period`=0 in RUN is ignored; the timer keeps running.
- **Priority, high to low:** `rst`, `stop`, `start`, normal counting.
- **Arithmetic:**
  - `cnt` never exceeds N_s−1, so no overflow. N_s = 2^width−1 is legal.
  - N_s−1 is computed in `width` bits; N_s≠0 is guaranteed by the start guard.
  - N_s=1: `cnt` stays 0 and a tick is produced every P_s+1 cycles.
- `busy` = (state==RUN); `done` = (state==DONE). Both are registered and change in the same cycle as the state.

## Timing
- `start` sampled at edge 0 → `busy`=1 from edge 0.
- First `cnt` increment at edge P+1; subsequent increments every P+1 edges.
- First `tick` is high in the cycle after edge N·(P+1), i.e. N·(P+1) cycles after `start` was sampled.
- Periodic mode: ticks exactly N·(P+1) cycles apart, with no gap cycle.
- One-shot mode: `tick` and `done` rise at the same edge; `busy` falls at that edge.
- `tick` is never high for 2 consecutive cycles unless N_s·(P_s+1)=1, i.e. N=1, P=0, periodic; then `tick` is continuously high.
- `stop` and `start` take effect at the sampling edge (1-cycle latency to outputs).
- `rst` mid-RUN: all outputs return to their reset values at the next edge; any pending tick is lost.

## Test plan
- **One-shot basic:** N=5, P=0, periodic=0, start pulse → `cnt` 0,1,2,3,4,0; `tick` high exactly 5 cycles after start; `done`=1 and `busy`=0 from the same edge; no further ticks.
- **Periodic with prescale:** N=3, P=2, periodic=1 → `cnt` holds each value for 3 cycles; ticks at 9, 18, 27 cycles after start; `busy` stays 1.
- **Input shadowing:** start with N=4, then change `period` to 7 and `prescale` to 5 while in RUN → ticks still every 4 cycles; a new start applies N=7, P=5 (tick every 42 cycles).
- **Stop/expiry collision:** N=2, P=0, periodic=0; assert `stop` on the expiry edge → no tick, state IDLE, `done`=0, `cnt`=0; `start`+`stop` together in IDLE → stays IDLE.
- **Boundaries:**
  - `period`=0 start → ignored, `busy` stays 0.
  - N=255 (width 8), P=0 → tick at 255 cycles; `cnt` max 254.
  - N=1, P=0, periodic → `tick` continuously high.
- **Reset mid-operation:** `rst` asserted while `cnt`=3 in RUN → next cycle `cnt`=0, `tick`=0, `busy`=0, `done`=0; a start afterwards behaves exactly as from power-up.
